icb_cfg_mst: RTL
================

Name: icb_cfg_mst

Overview:
ICB initiator that drives the register-config bus of ICB responder blocks, such as the DDS config slave with freq_ctrl_word at 0x00 and dds_en at 0x01.
Accepts write/read commands on a valid/ready command port and buffers them in a small FIFO.
Issues one ICB transaction at a time, waits for icb_wack/icb_rack, then returns a one-cycle response with read data.
Sits between a host/sequencer and one or more icb_dec-based config slaves.

Parameters:
AW, 8, ICB address width
DW, 32, ICB data width
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)
TO_CYC, 15, ack timeout in cycles (used only with the optional feature)

Ports:
clk  in  1  clock
rst_  in  1  reset, asynchronous, active-low
cmd_vld  in  1  command valid
cmd_rdy  out  1  command ready (=FIFO not full)
cmd_op  in  1  0=write, 1=read
cmd_adr  in  AW  register address
cmd_dat  in  DW  write data (ignored for reads)
rsp_vld  out  1  one-cycle response pulse, no backpressure
rsp_dat  out  DW  read data; 0 for writes
rsp_err  out  1  timeout flag, qualified by rsp_vld
busy  out  1  FIFO non-empty or FSM not IDLE
icb_wr  out  1  write strobe
icb_wadr  out  AW  write address
icb_wdat  out  DW  write data
icb_wack  in  1  write ack
icb_rd  out  1  read strobe
icb_radr  out  AW  read address
icb_rdat  in  DW  read data, valid while icb_rack=1
icb_rack  in  1  read ack

Behaviour:
- Reset (async, rst_=0):
  - FSM=IDLE, FIFO empty.
  - All outputs 0, except cmd_rdy=1 once reset is released.
  - Strobes drop immediately; any in-flight command is discarded with no response.
- Command FIFO:
  - Push on posedge when cmd_vld&cmd_rdy.
  - cmd_rdy=!full, independent of a same-cycle pop, so there is no push while full.
  - Push and pop in the same cycle are allowed when not full.
  - Pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits wide.
- FSM states IDLE, WR, RD, RSP:
  - IDLE: if FIFO non-empty, pop the head into the cmd register, then go to WR if op=0, else RD.
  - WR: icb_wr=1, icb_wadr/icb_wdat from the cmd register. Hold until icb_wack=1 is sampled at a posedge, then go to RSP with rsp_dat=0.
  - RD: icb_rd=1, icb_radr from the cmd register. Hold until icb_rack=1 is sampled; capture icb_rdat on that edge, then go to RSP.
  - RSP: rsp_vld=1 for exactly one cycle, then go to IDLE.
- Strobe and address/data outputs:
  - Decoded from registered state only; no combinational path from ICB inputs to ICB outputs.
  - icb_wadr/icb_wdat/icb_radr are 0 outside WR/RD.
- Latency:
  - Command accepted at edge T, slave acks in the same cycle: strobe high in the cycle after T+1, rsp_vld high in the cycle after T+2, IDLE at T+3.
  - Throughput is one command per 3 cycles.
- icb_wr and icb_rd are never high together.
- Strict FIFO order; responses return in command order.
- Ack arriving in a state other than WR/RD is ignored.
- rsp_dat holds its value until the next response.

Optional Feature:
Macro ICB_CFG_MST_TIMEOUT_EN.
- Defined:
  - A 4+ bit counter clears on entry to WR/RD and increments each cycle without ack.
  - When it reaches TO_CYC with no ack, the strobe drops and the FSM goes to RSP with rsp_err=1 and rsp_dat=0.
  - An ack in the same cycle as the limit wins (normal response, rsp_err=0).
- Not defined:
  - No counter exists; the FSM waits indefinitely in WR/RD.
  - rsp_err is tied to 0.

Test Plan:
1. Write adr 0x00 dat 0x0010_0000, slave acks combinationally -> icb_wr high exactly 1 cycle with wadr=0x00 and wdat=0x0010_0000; rsp_vld 3 cycles after accept, rsp_dat=0, rsp_err=0.
2. Write adr 0x01 dat 0x1, then read adr 0x01 with slave returning 0x0000_0001 -> icb_rd 1 cycle with radr=0x01; rsp_dat=0x0000_0001; responses in order.
3. Hold cmd_vld for 6 back-to-back commands with FIFO_DEPTH=4 -> cmd_rdy drops when the FIFO is full; all 6 issued in order; 6 rsp_vld pulses spaced 3 cycles apart; busy falls after the last.
4. Slave delays icb_rack by 5 cycles on a read of 0xA5A5_A5A5 -> icb_rd held 6 cycles; rsp_dat=0xA5A5_A5A5; no duplicate strobe.
5. With ICB_CFG_MST_TIMEOUT_EN, icb_wack tied 0 -> icb_wr high 15 cycles then low; rsp_vld with rsp_err=1; the next queued command proceeds. Without the macro -> icb_wr stays high and no response.
6. Assert rst_=0 mid-RD with 2 commands queued -> icb_rd drops asynchronously; after release no rsp_vld, FIFO empty, busy=0, cmd_rdy=1.

Source files
------------

// File: rtl/icb_cfg_mst_if.sv
// icb_cfg_mst_if - bundles the command port, response port and ICB
// register-config bus of the icb_cfg_mst initiator.
//
//   cmd_vld/cmd_rdy/cmd_op/cmd_adr/cmd_dat : host command handshake
//   rsp_vld/rsp_dat/rsp_err                : one-cycle response pulse
//   busy                                   : initiator has work pending
//   icb_wr/icb_wadr/icb_wdat/icb_wack      : ICB write channel
//   icb_rd/icb_radr/icb_rdat/icb_rack      : ICB read channel
//
// Modports: master = the icb_cfg_mst side, slave = host plus ICB responders.
interface icb_cfg_mst_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          cmd_vld;
  logic          cmd_rdy;
  logic          cmd_op;
  logic [AW-1:0] cmd_adr;
  logic [DW-1:0] cmd_dat;
  logic          rsp_vld;
  logic [DW-1:0] rsp_dat;
  logic          rsp_err;
  logic          busy;
  logic          icb_wr;
  logic [AW-1:0] icb_wadr;
  logic [DW-1:0] icb_wdat;
  logic          icb_wack;
  logic          icb_rd;
  logic [AW-1:0] icb_radr;
  logic [DW-1:0] icb_rdat;
  logic          icb_rack;

  modport master (
    input  cmd_vld, cmd_op, cmd_adr, cmd_dat, icb_wack, icb_rdat, icb_rack,
    output cmd_rdy, rsp_vld, rsp_dat, rsp_err, busy,
           icb_wr, icb_wadr, icb_wdat, icb_rd, icb_radr
  );

  modport slave (
    output cmd_vld, cmd_op, cmd_adr, cmd_dat, icb_wack, icb_rdat, icb_rack,
    input  cmd_rdy, rsp_vld, rsp_dat, rsp_err, busy,
           icb_wr, icb_wadr, icb_wdat, icb_rd, icb_radr
  );
endinterface

// File: rtl/icb_cfg_mst.sv
// icb_cfg_mst - ICB initiator for register-config slaves.
// Buffers write/read commands in a small FIFO, issues one ICB transaction
// at a time, waits for icb_wack/icb_rack and returns a one-cycle response
// (read data, 0 for writes).
//
// Ports:
//   clk  : clock
//   rst_ : asynchronous active-low reset
//   bus  : icb_cfg_mst_if.master (command, response, busy and ICB signals)
//
// Optional build macro ICB_CFG_MST_TIMEOUT_EN: when defined, a WR/RD that
// sees no ack for TO_CYC cycles is abandoned and answered with rsp_err=1.
// When undefined the FSM waits indefinitely and rsp_err is tied to 0.
module icb_cfg_mst #(
  parameter int AW         = 8,
  parameter int DW         = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TO_CYC     = 15
) (
  input  logic            clk,
  input  logic            rst_,
  icb_cfg_mst_if.master   bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = AW + DW + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TO_CYC < 1) begin : g_bad_param
    $error("icb_cfg_mst: FIFO_DEPTH must be a power of 2 >= 2 and TO_CYC >= 1");
  end

  typedef enum logic [1:0] {IDLE, WR, RD, RSP} state_t;

  state_t        state, state_nxt;
  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          rdy_en;
  logic          full, empty, push, pop;
  logic          cmd_op_q;
  logic [AW-1:0] cmd_adr_q;
  logic [DW-1:0] cmd_dat_q;
  logic [DW-1:0] rsp_dat_q;
  logic          ack_hit, timeout, rsp_load;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  // rdy_en keeps cmd_rdy low while reset is asserted and comes up one
  // clock after release.
  assign bus.cmd_rdy = rdy_en & ~full;
  assign push  = bus.cmd_vld & bus.cmd_rdy;
  assign pop   = (state == IDLE) & ~empty;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) rdy_en <= 1'b0;
    else       rdy_en <= 1'b1;
  end

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {bus.cmd_op, bus.cmd_adr, bus.cmd_dat};
  end

  // Power-of-2 depth lets the pointers wrap on natural overflow.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cmd_op_q  <= 1'b0;
      cmd_adr_q <= '0;
      cmd_dat_q <= '0;
    end else if (pop) begin
      {cmd_op_q, cmd_adr_q, cmd_dat_q} <= fifo_mem[rd_ptr];
    end
  end

  // An ack only counts in the state that owns the matching strobe.
  assign ack_hit  = ((state == WR) & bus.icb_wack) | ((state == RD) & bus.icb_rack);
  assign rsp_load = ((state == WR) | (state == RD)) & (ack_hit | timeout);

`ifdef ICB_CFG_MST_TIMEOUT_EN
  localparam int TW = ($clog2(TO_CYC + 1) > 4) ? $clog2(TO_CYC + 1) : 4;
  logic [TW-1:0] to_cnt;
  logic          rsp_err_q;

  // Counter is zero whenever a WR/RD is entered (IDLE always precedes it);
  // comparing against TO_CYC-1 makes the strobe last exactly TO_CYC cycles.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)                            to_cnt <= '0;
    else if (state == WR || state == RD)  to_cnt <= to_cnt + TW'(1);
    else                                  to_cnt <= '0;
  end
  assign timeout = (to_cnt == TW'(TO_CYC - 1));

  // A same-cycle ack beats the timeout.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)         rsp_err_q <= 1'b0;
    else if (rsp_load) rsp_err_q <= ~ack_hit;
  end
  assign bus.rsp_err = rsp_err_q;
`else
  assign timeout     = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty) state_nxt = fifo_mem[rd_ptr][EW-1] ? RD : WR;
      WR:      if (rsp_load) state_nxt = RSP;
      RD:      if (rsp_load) state_nxt = RSP;
      RSP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Held between responses; only a read that was actually acked returns data.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)         rsp_dat_q <= '0;
    else if (rsp_load) rsp_dat_q <= ((state == RD) && bus.icb_rack) ? bus.icb_rdat : '0;
  end

  // Bus outputs come purely from registered state and the cmd register.
  assign bus.icb_wr   = (state == WR);
  assign bus.icb_wadr = (state == WR) ? cmd_adr_q : '0;
  assign bus.icb_wdat = (state == WR) ? cmd_dat_q : '0;
  assign bus.icb_rd   = (state == RD);
  assign bus.icb_radr = (state == RD) ? cmd_adr_q : '0;
  assign bus.rsp_vld  = (state == RSP);
  assign bus.rsp_dat  = rsp_dat_q;
  assign bus.busy     = ~empty | (state != IDLE);

endmodule
